uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart of the UART transmit path, sharing its frame format (1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity). Synchronises the asynchronous `rx_in` line, detects and qualifies the start bit on a 16x oversampled baud tick, and samples each bit at mid-bit. Presents each received byte on a valid/ready interface toward the RX FIFO or bus register, and flags framing and overrun errors.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `DIV_W`, 16: width of the baud divisor.
- `clk` input 1: single clock for the block.
- `reset` input 1: synchronous, active-high reset.
- `baud_div` input DIV_W: oversample tick period minus 1, in `clk` cycles. One bit lasts 16 ticks. Static while not in IDLE.
- `rx_in` input 1: asynchronous serial line; idles high.
- `rx_data` output DATA_BITS: received byte; stable while `rx_valid` is high.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0.
- `overrun_err` output 1: one-cycle pulse when a good byte completes while the holding register is still full.
- `busy` output 1: FSM not in IDLE.

## Operation
- **Input synchroniser:** `rx_in` passes through a 2-flop synchroniser, giving `rx_s`. Both flops reset to 1. All logic uses `rx_s` only.
- **Tick generator:** counts 0..`baud_div` and emits `tick` for 1 cycle when the count equals `baud_div`. The counter is cleared to 0 on the IDLE→START transition, which aligns the tick phase to the start edge.
- **Tick counter** (4 bits) and **bit index** (`$clog2(DATA_BITS)` bits) are held in the FSM datapath.
- **FSM states:**
  - **IDLE:** when `rx_s == 0`, go to START and clear the prescaler and tick counter.
  - **START:** on the 8th tick (mid-bit), if `rx_s == 0`, go to DATA with tick count 0 and bit index 0. If `rx_s == 1`, treat it as a glitch and return to IDLE with no output.
  - **DATA:** on every 16th tick, shift `rx_s` into the MSB of the shift register (right shift, so the byte is LSB first). After bit index DATA_BITS-1, go to STOP.
  - **STOP:** on the 16th tick, sample `rx_s`.
    - If 1: deliver the byte, then go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rx_s == 1`, then go to IDLE. A held-low line therefore produces exactly one `frame_err`.
- **Delivery:** on the cycle after the good stop sample:
  - If the holding register is empty, or being accepted in that same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: keep the old byte, drop the new one, and pulse `overrun_err`.
- **Handshake:** `rx_valid` clears on the cycle after `rx_valid && rx_ready`. Simultaneous accept and deliver leaves `rx_valid` high with the new data.
- **Reset values:** `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun_err` = 0, `busy` = 0. FSM = IDLE, all counters 0.
- **Reset mid-frame:** the partial frame is abandoned and no output pulses are generated. A frame already in flight on the line may then be seen as a start from a data 0. This is accepted behaviour.

## Timing
- One tick = `baud_div`+1 clocks. One bit = 16 ticks.
- Edge detection: START is entered 3 clocks after the `rx_in` falling edge (2 synchroniser flops plus 1 FSM register).
- Sample points, measured in ticks from START entry:
  - Start qualification at tick 8.
  - Data bit k at tick 8+16(k+1).
  - Stop bit at tick 8+16(DATA_BITS+1).
- `rx_valid`, `frame_err` and `overrun_err` assert 1 clock after the stop-sample tick.
- Back-to-back frames are supported. IDLE re-arms at mid-stop, so the next falling edge may arrive ≥ half a bit later.
- Tolerated baud mismatch: ±3% (inherent to mid-bit sampling at 16x).

## Structure
- **Shared package `uart_pkg`:**
  - `rx_state_t` enum {IDLE, START, DATA, STOP, BREAK}.
  - Constant `OVERSAMPLE = 16`.
  - Constant `MID_SAMPLE = 8`.
- **Sub-module `uart_baud_tick`:** parameter DIV_W; ports `clk`, `reset`, `clr`, `baud_div`, `tick`. It is reusable by the TX path.
- **Main module:** synchroniser, FSM, shift register and holding register live in `uart_rx`.

## Test plan
All scenarios use `baud_div` = 3, i.e. 4 clocks per tick and 64 clocks per bit.

- **Single byte:** send 0xA5 with `rx_ready` held high. Require `rx_data` = 0xA5 and a 1-cycle `rx_valid`. The stop sample occurs 608 clocks after START entry.
- **Glitch rejection:** drive a 20-clock low pulse on idle `rx_in`. Require return to IDLE by tick 8, no `rx_valid`, no errors, and `busy` to drop.
- **Framing error:** send 0x3C with the stop bit forced to 0, and hold the line low for 3 more bit times. Require exactly one `frame_err` pulse, no `rx_valid`, and a wait in BREAK until the line goes high. A following 0x55 must then be received correctly.
- **Overrun:** send 0x11 then 0x22 back-to-back with `rx_ready` = 0. Require `rx_data` to stay 0x11 and `overrun_err` to pulse once at the second stop. After `rx_ready` is raised, one accept, then `rx_valid` = 0.
- **Simultaneous accept and deliver:** assert `rx_ready` for the cycle coincident with the second byte's delivery (0xF0 then 0x0F). Require `rx_valid` to stay high with `rx_data` = 0x0F and no `overrun_err`.
- **Reset mid-frame:** assert `reset` for 1 cycle at data bit 4 of 0xFF. Require all outputs = 0 and FSM in IDLE. The next frame 0x81 must be received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Contents:
//   rx_state_t  receiver FSM states
//   OVERSAMPLE  baud ticks per bit
//   MID_SAMPLE  tick within the start bit used to qualify it
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - valid/ready byte stream from the UART receiver
// Signals:
//   rx_data   received byte, stable while rx_valid is high
//   rx_valid  rx_data holds an unconsumed byte
//   rx_ready  consumer accepts the byte when rx_valid && rx_ready
// Modports: master (receiver side), slave (consumer side)
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr         restart the period from 0 (aligns tick phase to an event)
//   baud_div    tick period minus 1, in clk cycles
//   tick        one-cycle pulse when the count reaches baud_div
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == baud_div);

  always_ff @(posedge clk) begin
    if (reset || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver (8N1-style, DATA_BITS data bits)
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   baud_div     oversample tick period minus 1; static while busy
//   rx_in        asynchronous serial line, idles high
//   rx_bus       received byte stream (master side)
//   frame_err    one-cycle pulse when the stop bit samples 0
//   overrun_err  one-cycle pulse when a good byte finds the holding register full
//   busy         receiver not idle
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx_in,
  uart_rx_if.master        rx_bus,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             busy
);
  import uart_pkg::*;

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t            state, state_next;
  logic                 rx_meta, rx_s;
  logic                 tick, tick_clr;
  logic [3:0]           tick_cnt, tick_cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 good_stop, bad_stop;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clr      (tick_clr),
    .baud_div (baud_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state;
    tick_clr      = 1'b0;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    good_stop     = 1'b0;
    bad_stop      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next    = START;
          tick_clr      = 1'b1;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == 4'(MID_SAMPLE - 1)) begin
            // Line back high at mid start bit: a glitch, not a frame.
            state_next    = rx_s ? IDLE : DATA;
            tick_cnt_next = '0;
            bit_idx_next  = '0;
          end else begin
            tick_cnt_next = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          // 4-bit counter wraps to 0 on the 16th tick, restarting the bit.
          tick_cnt_next = tick_cnt + 4'd1;
          if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
            shift_next = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx + IDX_W'(1);
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_next = tick_cnt + 4'd1;
          if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
            // Re-arm at mid stop bit so back-to-back frames are caught.
            good_stop  = rx_s;
            bad_stop   = !rx_s;
            state_next = rx_s ? IDLE : BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register: an accept in the delivery cycle frees the slot,
  // so the new byte replaces the old one instead of overrunning.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= bad_stop;
      overrun_err <= 1'b0;
      if (good_stop) begin
        if (!valid_q || rx_bus.rx_ready) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (valid_q && rx_bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data  = data_q;
  assign rx_bus.rx_valid = valid_q;
  assign busy            = (state != IDLE);

endmodule
